// File: rtl/mag_window_gen.sv
// Builds 3x3 gradient-magnitude windows from a raster pixel stream for the NMS stage.
// Two magnitude line buffers, one direction line buffer and a short column history per window row.
module mag_window_gen #(
    parameter int NBIT_INPUT = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_valid,
    input  logic                                 i_sof,
    input  logic [NBIT_INPUT-1:0]                i_mag,
    input  logic [1:0]                           i_dir,
    output logic                                 o_valid,
    output logic [2:0][2:0][NBIT_INPUT-1:0]      kernel,
    output logic [1:0]                           o_direction,
    output logic                                 o_last
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col, col_eff;
    logic [RW-1:0] row, row_eff;
    logic          accept, emit, col_end, row_end;

    logic [NBIT_INPUT-1:0] lb_r1 [IMG_WIDTH];
    logic [NBIT_INPUT-1:0] lb_r2 [IMG_WIDTH];
    logic [1:0]            lb_dir[IMG_WIDTH];

    // Per window row: the two previously accepted columns (c-2, c-1) plus the incoming column c.
    logic [2:0][1:0][NBIT_INPUT-1:0] hist;
    logic [2:0][NBIT_INPUT-1:0]      new_col;
    logic [1:0]                      dir_rd, dir_prev;

    always_comb begin
        accept     = i_valid && !i_rst;
        col_eff    = i_sof ? '0 : col;
        row_eff    = i_sof ? '0 : row;
        col_end    = (col_eff == COL_LAST);
        row_end    = (row_eff == ROW_LAST);
        emit       = accept && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
        new_col[0] = lb_r2[col_eff];
        new_col[1] = lb_r1[col_eff];
        new_col[2] = i_mag;
        dir_rd     = lb_dir[col_eff];
    end

    // Line buffers are plain RAM; border gating keeps stale contents off the outputs.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb_r2[col_eff]  <= lb_r1[col_eff];
            lb_r1[col_eff]  <= i_mag;
            lb_dir[col_eff] <= i_dir;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col         <= '0;
            row         <= '0;
            hist        <= '0;
            dir_prev    <= '0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            kernel      <= '0;
            o_direction <= '0;
        end else begin
            o_valid <= emit;
            o_last  <= emit && col_end && row_end;
            if (accept) begin
                col <= col_end ? '0 : col_eff + CW'(1);
                if (col_end)
                    row <= row_end ? '0 : row_eff + RW'(1);
                else
                    row <= row_eff;
                for (int i = 0; i < 3; i++) begin
                    hist[i][0] <= hist[i][1];
                    hist[i][1] <= new_col[i];
                end
                dir_prev <= dir_rd;
            end
            if (emit) begin
                for (int i = 0; i < 3; i++) begin
                    kernel[i][0] <= hist[i][0];
                    kernel[i][1] <= hist[i][1];
                    kernel[i][2] <= new_col[i];
                end
                // Center is column c-1 of row r-1, read from the line buffer one accept earlier.
                o_direction <= dir_prev;
            end
        end
    end

endmodule

// File: tb/tb_mag_window_gen.sv
// Directed bench for mag_window_gen on an 8x6 image: ramp frames, gaps, SOF resync, reset abort, back-to-back.
module tb_mag_window_gen;

    localparam int NB = 12;
    localparam int W  = 8;
    localparam int H  = 6;

    logic                         i_clk = 1'b0;
    logic                         i_rst, i_valid, i_sof;
    logic [NB-1:0]                i_mag;
    logic [1:0]                   i_dir;
    logic                         o_valid, o_last;
    logic [2:0][2:0][NB-1:0]      kernel;
    logic [1:0]                   o_direction;

    int n_chk = 0;
    int n_err = 0;
    int n_win, n_last;
    logic [2:0][2:0][NB-1:0] last_k;
    logic [1:0]              last_d;

    mag_window_gen #(.NBIT_INPUT(NB), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sof(i_sof),
        .i_mag(i_mag), .i_dir(i_dir), .o_valid(o_valid), .kernel(kernel),
        .o_direction(o_direction), .o_last(o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tally();
        if (o_valid) n_win++;
        if (o_valid && o_last) n_last++;
    endtask

    // Idle cycle with junk on the data inputs: outputs must not validate and must hold.
    task automatic idle();
        i_valid = 1'b0;
        i_sof   = 1'($urandom);
        i_mag   = NB'($urandom);
        i_dir   = 2'($urandom);
        @(posedge i_clk); #1;
        i_sof = 1'b0;
        check("idle_valid", 128'(o_valid), 128'(0));
        check("idle_last", 128'(o_last), 128'(0));
        check("idle_hold_kernel", 128'(kernel), 128'(last_k));
        check("idle_hold_dir", 128'(o_direction), 128'(last_d));
        tally();
    endtask

    // Pixel (r,c) carries mag = base + 10*r + c, dir = (r+c)%4. Stops before (stop_r, stop_c).
    task automatic frame(input int base, input bit sof0, input bit gaps, input int stop_r, input int stop_c);
        logic [2:0][2:0][NB-1:0] ek;
        logic [1:0]              ed;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (gaps) repeat ($urandom_range(0, 1)) idle();
                i_valid = 1'b1;
                i_sof   = sof0 && r == 0 && c == 0;
                i_mag   = NB'(base + 10 * r + c);
                i_dir   = 2'((r + c) % 4);
                @(posedge i_clk); #1;
                i_valid = 1'b0;
                i_sof   = 1'b0;
                if (r >= 2 && c >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            ek[i][j] = NB'(base + 10 * (r - 2 + i) + (c - 2 + j));
                    ed = 2'((r + c - 2) % 4);
                    check("win_valid", 128'(o_valid), 128'(1));
                    check("win_kernel", 128'(kernel), 128'(ek));
                    check("win_dir", 128'(o_direction), 128'(ed));
                    check("win_last", 128'(o_last), 128'(r == H - 1 && c == W - 1));
                    last_k = ek;
                    last_d = ed;
                end else begin
                    check("border_valid", 128'(o_valid), 128'(0));
                end
                tally();
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_mag = '0; i_dir = '0;
        last_k = '0; last_d = '0;
        repeat (2) @(posedge i_clk); #1;
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_last", 128'(o_last), 128'(0));
        check("rst_kernel", 128'(kernel), 128'(0));
        check("rst_dir", 128'(o_direction), 128'(0));
        i_rst = 1'b0;

        // Continuous ramp frame
        n_win = 0; n_last = 0;
        frame(0, 1'b1, 1'b0, -1, -1);
        check("ramp_windows", 128'(n_win), 128'(24));
        check("ramp_last", 128'(n_last), 128'(1));
        check("ramp_last_center", 128'(kernel[1][1]), 128'(46));

        // Same ramp with random gaps
        n_win = 0; n_last = 0;
        frame(200, 1'b1, 1'b1, -1, -1);
        check("gap_windows", 128'(n_win), 128'(24));
        check("gap_last", 128'(n_last), 128'(1));

        // SOF at counted (3,4) restarts the frame
        n_win = 0; n_last = 0;
        frame(300, 1'b0, 1'b0, 3, 4);
        check("sof_partial_windows", 128'(n_win), 128'(8));
        n_win = 0;
        frame(400, 1'b1, 1'b0, -1, -1);
        check("sof_windows", 128'(n_win), 128'(24));
        check("sof_last", 128'(n_last), 128'(1));

        // Reset at pixel (4,3) aborts the frame
        frame(500, 1'b0, 1'b0, 4, 3);
        i_rst = 1'b1; i_valid = 1'b1; i_mag = NB'(777); i_dir = 2'd3;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_valid = 1'b0;
        check("abort_valid", 128'(o_valid), 128'(0));
        check("abort_last", 128'(o_last), 128'(0));
        check("abort_kernel", 128'(kernel), 128'(0));
        check("abort_dir", 128'(o_direction), 128'(0));
        last_k = '0; last_d = '0;
        idle();
        n_win = 0; n_last = 0;
        frame(600, 1'b0, 1'b0, -1, -1);
        check("post_rst_windows", 128'(n_win), 128'(24));
        check("post_rst_last", 128'(n_last), 128'(1));

        // Back-to-back frames, second one relies on counter wrap
        n_win = 0; n_last = 0;
        frame(700, 1'b1, 1'b0, -1, -1);
        frame(800, 1'b0, 1'b0, -1, -1);
        check("b2b_windows", 128'(n_win), 128'(48));
        check("b2b_last", 128'(n_last), 128'(2));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
